// File: rtl/serial_xor_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial XOR engine.
// Operands are XORed LSB first, one bit per clock, through a single
// mux-built XOR gate; the result is returned with the owning requester id.

// 2:1 multiplexer primitive used to build the XOR engine.
module mux2 (
   input  logic sel,
   input  logic d0,
   input  logic d1,
   output logic y
);
   assign y = sel ? d1 : d0;
endmodule

// One-bit XOR built only from mux primitives: y = a ? ~b : b.
module xor_gate_using_mux (
   input  logic a,
   input  logic b,
   output logic y
);
   logic b_n_s;

   mux2 u_inv (.sel(b), .d0(1'b1), .d1(1'b0), .y(b_n_s));
   mux2 u_out (.sel(a), .d0(b),    .d1(b_n_s), .y(y));
endmodule

module serial_xor_arbiter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [W-1:0] in0_a,
   input  logic [W-1:0] in0_b,
   input  logic         in1_valid,
   output logic         in1_ready,
   input  logic [W-1:0] in1_a,
   input  logic [W-1:0] in1_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_id
);
   localparam int CNT_W = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [W-1:0]     a_sh_r;
   logic [W-1:0]     b_sh_r;
   logic [W-1:0]     res_r;
   logic [W-1:0]     res_nxt_s;
   logic [W-1:0]     out_data_r;
   logic [CNT_W-1:0] cnt_r;
   logic             id_r;
   logic             last_grant_r;
   logic             out_id_r;
   logic             out_valid_r;
   logic             winner_s;
   logic             accept_s;
   logic             xor_bit_s;
   logic             cnt_last_s;

   // The only XOR in the datapath: current LSBs of the operand shifters.
   xor_gate_using_mux u_xor (
      .a(a_sh_r[0]),
      .b(b_sh_r[0]),
      .y(xor_bit_s)
   );

   assign cnt_last_s = (cnt_r == CNT_W'(W - 1));

   // Result bits enter at the MSB so LSB-first bits land in natural order.
   if (W == 1) begin : g_res_one
      assign res_nxt_s = xor_bit_s;
   end else begin : g_res_wide
      assign res_nxt_s = {xor_bit_s, res_r[W-1:1]};
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_id    = out_id_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Round-robin arbitration in IDLE and next-state selection.
   always_comb begin
      state_nxt_s = state_r;
      winner_s    = 1'b0;
      accept_s    = 1'b0;
      in0_ready   = 1'b0;
      in1_ready   = 1'b0;
      case (state_r)
         IDLE: begin
            if (in0_valid && in1_valid) begin
               winner_s = ~last_grant_r;
            end else if (in1_valid) begin
               winner_s = 1'b1;
            end else begin
               winner_s = 1'b0;
            end
            // A cycle with rst high never completes a handshake.
            if ((in0_valid || in1_valid) && !rst) begin
               accept_s    = 1'b1;
               in0_ready   = ~winner_s;
               in1_ready   = winner_s;
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Operand load, bit-serial shifting and result/output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r       <= {W{1'b0}};
         b_sh_r       <= {W{1'b0}};
         res_r        <= {W{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
         out_data_r   <= {W{1'b0}};
         out_id_r     <= 1'b0;
         out_valid_r  <= 1'b0;
      end else if (accept_s) begin
         a_sh_r       <= winner_s ? in1_a : in0_a;
         b_sh_r       <= winner_s ? in1_b : in0_b;
         cnt_r        <= {CNT_W{1'b0}};
         id_r         <= winner_s;
         last_grant_r <= winner_s;
      end else if (state_r == SHIFT) begin
         a_sh_r <= a_sh_r >> 1'b1;
         b_sh_r <= b_sh_r >> 1'b1;
         res_r  <= res_nxt_s;
         cnt_r  <= cnt_r + CNT_W'(1);
         // Capture the finished word so the output stays stable in DONE.
         if (cnt_last_s) begin
            out_data_r  <= res_nxt_s;
            out_id_r    <= id_r;
            out_valid_r <= 1'b1;
         end
      end else if ((state_r == DONE) && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end
endmodule
